// File: rtl/gray_to_bin_serial.sv
// Serial Gray-to-binary decoder: resolves one bit per clock, MSB first, behind valid/ready.
// Optional macro GRAY_STEP_CHECK_EN adds a single-bit-step check between accepted words.
module gray_to_bin_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] G,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             step_err
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   b_ext;
  logic [IdxW:0]    idx_up;
  logic             accept;

  assign accept = (state_q == StIdle) && in_valid;
  // Zero above the MSB lets the top bit use the same XOR rule as the rest.
  assign b_ext  = {1'b0, b_q};
  assign idx_up = {1'b0, idx_q} + (IdxW+1)'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    g_d     = g_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          g_d     = G;
          b_d     = '0;
          idx_d   = IdxW'(WIDTH - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        b_d[idx_q] = b_ext[idx_up] ^ g_q[idx_q];
        if (idx_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= IdxW'(WIDTH - 1);
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign B         = b_q;

`ifdef GRAY_STEP_CHECK_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] diff;
  logic [CntW-1:0]  diff_cnt;
  logic             first_q;
  logic             step_bad_q;
  logic             step_err_q;

  assign diff = G ^ prev_q;

  always_comb begin
    diff_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff_cnt = diff_cnt + CntW'(diff[i]);
    end
  end

  // Verdict is taken at accept (prev_q moves then) and published on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      first_q    <= 1'b1;
      step_bad_q <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      if (accept) begin
        prev_q     <= G;
        first_q    <= 1'b0;
        step_bad_q <= !first_q && (diff_cnt != CntW'(1));
      end
      if (state_q == StShift && state_d == StDone) begin
        step_err_q <= step_bad_q;
      end else if (state_q == StDone && state_d == StIdle) begin
        step_err_q <= 1'b0;
      end
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: doc/gray_to_bin_serial.md
Name: gray_to_bin_serial

Overview:
- Sequential Gray-to-binary decoder. The inverse of the team's 4-bit binary-to-Gray converter.
- Accepts one WIDTH-bit Gray word over a valid/ready handshake and resolves the binary value serially, MSB first, one bit per clock.
- Presents the result on a held output handshake.
- Used wherever Gray-coded counters/pointers must be turned back into binary without a long combinational XOR chain.

Parameters:
- WIDTH, 4, word width in bits (legal range 2..16).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  G holds a word to decode.
- in_ready  output  1  block can accept a word (high only in IDLE).
- G  input  WIDTH  Gray-coded input word.
- out_valid  output  1  B holds a decoded word.
- out_ready  input  1  consumer takes B.
- B  output  WIDTH  decoded binary word.
- busy  output  1  high in SHIFT or DONE.
- step_err  output  1  Gray step violation flag, qualified by out_valid (see Optional Feature).

Behaviour:
- Reset (rst high at posedge): state=IDLE, in_ready=1, out_valid=0, busy=0, B=0, step_err=0, bit index=WIDTH-1, captured word=0, previous-word register=0, first-word flag=1.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On posedge with in_valid=1, capture G into an internal register g_q, clear B, go to SHIFT with idx=WIDTH-1.
  - With in_valid=0, stay in IDLE.
- SHIFT:
  - Each posedge resolves one bit: B[idx] = g_q[idx] when idx=WIDTH-1, else B[idx+1] ^ g_q[idx].
  - Then idx decrements. After the posedge that resolves idx=0, go to DONE.
  - Takes exactly WIDTH cycles.
  - in_ready=0. Changes on G/in_valid are ignored.
- DONE:
  - out_valid=1. B and step_err are held stable.
  - On posedge with out_ready=1: out_valid drops and state returns to IDLE.
  - out_ready=0 holds DONE indefinitely with no change to outputs.
- Latency: out_valid rises WIDTH cycles after the accepting edge.
- Throughput: one word per WIDTH+2 cycles minimum (accept edge, WIDTH shift edges, release edge). There is no overlap of accept with DONE.
- B is only meaningful while out_valid=1. Partial bits are visible during SHIFT, and the consumer must not sample them.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values. The in-flight word is discarded and no out_valid pulse is produced.
- Reset has priority over any simultaneous handshake.
- out_ready while not in DONE: ignored.
- Functional result: B equals the standard prefix-XOR inverse of Gray encoding. B[i] = XOR of G[WIDTH-1:i].

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- With the macro defined:
  - Each accepted word is compared with the previously accepted word (previous-word register updated at every accept).
  - step_err is set on entry to DONE if the two words differ in a number of bits other than exactly one, which includes identical words.
  - The first word after reset never flags (first-word flag then clears).
  - Wrap from the top Gray code to 0 is a legal one-bit step.
  - step_err is held through DONE and cleared on leaving DONE.
- Without the macro: the step_err port still exists and is tied to 0. The previous-word register, popcount logic and first-word flag are not built.

Test Plan:
- WIDTH=4, reset held 2 cycles -> in_ready=1, out_valid=0, B=0000, busy=0.
- Accept G=0110, out_ready=1 -> out_valid rises exactly 4 cycles after accept edge with B=0100. Then G=1000 -> B=1111. Then G=0000 -> B=0000.
- Sweep all 16 Gray codes in count order (0000,0001,0011,...,1000) back-to-back -> B equals 0..15. in_ready is low during each SHIFT/DONE. With GRAY_STEP_CHECK_EN, step_err=0 throughout, including the 1000->0000 wrap.
- Accept 0101, hold out_ready=0 for 10 cycles -> out_valid stays 1, B=0110 stable, in_ready=0 and a new in_valid is ignored. Raise out_ready -> IDLE next cycle.
- Accept 1010, assert rst during the 2nd SHIFT cycle -> all outputs at reset values next cycle and no out_valid for that word. The next accept of 0011 decodes to 0010.
- GRAY_STEP_CHECK_EN: send 0000, then 0011, then 0011, then 0010 -> step_err = 0, 1, 1, 0 on the respective out_valid. Without the macro, all four give 0.
